// File: rtl/cordic_pkg.sv
// Shared Q2.30 constants, arctangent table and FSM state type for the CORDIC rotator.
package cordic_pkg;

  localparam int WIDTH     = 32;
  localparam int FRAC_BITS = 30;

  localparam logic signed [WIDTH-1:0] PI_2     = 32'sh6487ED51;
  localparam logic signed [WIDTH-1:0] CORDIC_K = 32'sh26DD3B6A;
  localparam logic signed [WIDTH-1:0] ONE      = 32'sh40000000;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ROTATE = 2'd1,
    DONE   = 2'd2
  } state_t;

  // atan(2^-i) in Q2.30; beyond i=10 the value is 2^(30-i) less a sub-LSB term.
  function automatic logic signed [WIDTH-1:0] atan_lut(input logic [4:0] i);
    logic signed [WIDTH-1:0] a;
    case (i)
      5'd0:    a = 32'sh3243F6A9;
      5'd1:    a = 32'sh1DAC6705;
      5'd2:    a = 32'sh0FADBAFD;
      5'd3:    a = 32'sh07F56EA7;
      5'd4:    a = 32'sh03FEAB77;
      5'd5:    a = 32'sh01FFD55C;
      5'd6:    a = 32'sh00FFFAAB;
      5'd7:    a = 32'sh007FFF55;
      5'd8:    a = 32'sh003FFFEB;
      5'd9:    a = 32'sh001FFFFD;
      5'd10:   a = 32'sh00100000;
      5'd11:   a = 32'sh00080000;
      5'd12:   a = 32'sh00040000;
      5'd13:   a = 32'sh00020000;
      5'd14:   a = 32'sh00010000;
      5'd15:   a = 32'sh00008000;
      5'd16:   a = 32'sh00004000;
      5'd17:   a = 32'sh00002000;
      5'd18:   a = 32'sh00001000;
      5'd19:   a = 32'sh00000800;
      5'd20:   a = 32'sh00000400;
      5'd21:   a = 32'sh00000200;
      5'd22:   a = 32'sh00000100;
      5'd23:   a = 32'sh00000080;
      5'd24:   a = 32'sh00000040;
      5'd25:   a = 32'sh00000020;
      5'd26:   a = 32'sh00000010;
      5'd27:   a = 32'sh00000008;
      5'd28:   a = 32'sh00000004;
      5'd29:   a = 32'sh00000002;
      default: a = 32'sh00000001;
    endcase
    return a;
  endfunction

endpackage

// File: rtl/cordic_rotator_stage.sv
// One combinational CORDIC micro-rotation (rotation mode), driven by the sign of z.
module cordic_stage
  import cordic_pkg::*;
(
  input  logic signed [WIDTH-1:0] x,
  input  logic signed [WIDTH-1:0] y,
  input  logic signed [WIDTH-1:0] z,
  input  logic        [4:0]       i,
  output logic signed [WIDTH-1:0] x_nxt,
  output logic signed [WIDTH-1:0] y_nxt,
  output logic signed [WIDTH-1:0] z_nxt
);

  logic signed [WIDTH-1:0] xs;
  logic signed [WIDTH-1:0] ys;
  logic signed [WIDTH-1:0] a;

  always_comb begin
    xs = x >>> i;
    ys = y >>> i;
    a  = atan_lut(i);
    // z == 0 rotates in the positive direction
    if (!z[WIDTH-1]) begin
      x_nxt = x - ys;
      y_nxt = y + xs;
      z_nxt = z - a;
    end else begin
      x_nxt = x + ys;
      y_nxt = y - xs;
      z_nxt = z + a;
    end
  end

endmodule

// File: rtl/cordic_rotator.sv
// Iterative rotation-mode CORDIC: Q2.30 angle in, cos/sin out, one micro-rotation per clock.
// Build option CORDIC_GAIN_COMP_EN seeds x with K so outputs are unscaled cos/sin.
//
// state  | meaning
// IDLE   | ready for an angle
// ROTATE | running ITER micro-rotations
// DONE   | result (or domain error) held until out_ready
module cordic_rotator
  import cordic_pkg::*;
#(
  parameter int ITER = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_theta,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_cos,
  output logic [WIDTH-1:0] out_sin,
  output logic             out_err
);

`ifdef CORDIC_GAIN_COMP_EN
  localparam logic signed [WIDTH-1:0] X0 = CORDIC_K;
`else
  localparam logic signed [WIDTH-1:0] X0 = ONE;
`endif
  localparam logic [4:0] LAST = 5'(ITER - 1);

  state_t                  state, state_nxt;
  logic signed [WIDTH-1:0] x, y, z;
  logic signed [WIDTH-1:0] x_n, y_n, z_n;
  logic        [4:0]       i;
  logic                    theta_bad;
  logic                    accept;
  logic                    last;

  cordic_stage u_stage (
    .x     (x),
    .y     (y),
    .z     (z),
    .i     (i),
    .x_nxt (x_n),
    .y_nxt (y_n),
    .z_nxt (z_n)
  );

  assign theta_bad = ($signed(in_theta) > PI_2) || ($signed(in_theta) < -PI_2);
  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    last      = (i == LAST);
    case (state)
      IDLE: if (in_valid) begin
        accept    = 1'b1;
        state_nxt = theta_bad ? DONE : ROTATE;
      end
      ROTATE:  if (last) state_nxt = DONE;
      DONE:    if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= IDLE;
      x       <= '0;
      y       <= '0;
      z       <= '0;
      i       <= '0;
      out_cos <= '0;
      out_sin <= '0;
      out_err <= 1'b0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: if (accept) begin
          if (theta_bad) begin
            out_err <= 1'b1;
            out_cos <= '0;
            out_sin <= '0;
          end else begin
            x <= X0;
            y <= '0;
            z <= $signed(in_theta);
            i <= '0;
          end
        end
        ROTATE: begin
          x <= x_n;
          y <= y_n;
          z <= z_n;
          i <= i + 5'd1;
          if (last) begin
            out_cos <= x_n;
            out_sin <= y_n;
            out_err <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_cordic_rotator.sv
// Directed self-checking bench for cordic_rotator; expectations follow CORDIC_GAIN_COMP_EN.
module tb_cordic_rotator;

  localparam int ITER = 16;
  localparam int TOL  = 32'h10000;

  localparam logic [31:0] TH_PI6  = 32'h2182A470;
  localparam logic [31:0] TH_MPI2 = 32'h9B7812AF;
  localparam logic [31:0] TH_PI2  = 32'h6487ED51;
`ifdef CORDIC_GAIN_COMP_EN
  localparam logic [31:0] C0  = 32'h40000000;
  localparam logic [31:0] C6  = 32'h376CF5D1;
  localparam logic [31:0] S6  = 32'h20000000;
  localparam logic [31:0] S90 = 32'h40000000;
  localparam logic [31:0] SM  = 32'hC0000000;
`else
  localparam logic [31:0] C0  = 32'h69648E87;
  localparam logic [31:0] C6  = 32'h5B45D8F9;
  localparam logic [31:0] S6  = 32'h34B24744;
  localparam logic [31:0] S90 = 32'h69648E87;
  localparam logic [31:0] SM  = 32'h969B7179;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_theta;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_cos;
  logic [31:0] out_sin;
  logic        out_err;

  int errors = 0;
  int checks = 0;

  cordic_rotator #(.ITER(ITER)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_theta  (in_theta),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_cos   (out_cos),
    .out_sin   (out_sin),
    .out_err   (out_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp,
                       input int tol);
    logic signed [31:0] d;
    int ad;
    checks++;
    d  = $signed(got - exp);
    ad = (d < 0) ? -int'(d) : int'(d);
    if (ad > tol) begin
      errors++;
      $display("FAIL %s: got %h expected %h (tol %0d)", tag, got, exp, tol);
    end
  endtask

  // Present one angle, return the number of edges after the accepting edge until out_valid.
  task automatic run(input logic [31:0] th, output int n);
    @(negedge clk);
    in_valid = 1'b1;
    in_theta = th;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_theta = $urandom;
    n = 0;
    while (!out_valid && n < 60) begin
      @(posedge clk);
      #1;
      n++;
    end
  endtask

  task automatic drain(input string tag);
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    check({tag, "_drain_valid"}, {31'd0, out_valid}, 32'd0, 0);
    check({tag, "_drain_ready"}, {31'd0, in_ready}, 32'd1, 0);
  endtask

  task automatic legal(input string tag, input logic [31:0] th, input logic [31:0] ec,
                       input logic [31:0] es);
    int n;
    run(th, n);
    check({tag, "_lat"}, n, ITER, 0);
    check({tag, "_cos"}, out_cos, ec, TOL);
    check({tag, "_sin"}, out_sin, es, TOL);
    check({tag, "_err"}, {31'd0, out_err}, 32'd0, 0);
    drain(tag);
  endtask

  task automatic domain(input string tag, input logic [31:0] th);
    int n;
    run(th, n);
    check({tag, "_lat"}, n, 0, 0);
    check({tag, "_err"}, {31'd0, out_err}, 32'd1, 0);
    check({tag, "_cos"}, out_cos, 32'd0, 0);
    check({tag, "_sin"}, out_sin, 32'd0, 0);
    drain(tag);
  endtask

  initial begin
    logic [31:0] hold_cos, hold_sin;
    logic        spurious;
    int          n;

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_theta  = '0;
    out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_ready", {31'd0, in_ready}, 32'd1, 0);
    check("rst_valid", {31'd0, out_valid}, 32'd0, 0);
    check("rst_cos", out_cos, 32'd0, 0);
    check("rst_sin", out_sin, 32'd0, 0);
    check("rst_err", {31'd0, out_err}, 32'd0, 0);
    @(negedge clk);
    rst_n = 1'b1;

    legal("zero", 32'h0, C0, 32'h0);
    legal("pi6", TH_PI6, C6, S6);
    legal("mpi2", TH_MPI2, 32'h0, SM);
    legal("pi2", TH_PI2, 32'h0, S90);

    domain("big", 32'h70000000);
    domain("edge", 32'h6487ED52);
    domain("neg", 32'h80000000);
    legal("after_err", TH_PI6, C6, S6);

    // backpressure: result must hold while out_ready stays low
    run(32'h0, n);
    check("bp_lat", n, ITER, 0);
    hold_cos = out_cos;
    hold_sin = out_sin;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk);
      #1;
      check("bp_valid", {31'd0, out_valid}, 32'd1, 0);
      check("bp_ready", {31'd0, in_ready}, 32'd0, 0);
      check("bp_cos", out_cos, hold_cos, 0);
      check("bp_sin", out_sin, hold_sin, 0);
    end
    drain("bp");

    // reset in the middle of a rotation
    @(negedge clk);
    in_valid = 1'b1;
    in_theta = TH_PI6;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (7) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    check("mid_rst_ready", {31'd0, in_ready}, 32'd1, 0);
    check("mid_rst_valid", {31'd0, out_valid}, 32'd0, 0);
    check("mid_rst_cos", out_cos, 32'd0, 0);
    check("mid_rst_sin", out_sin, 32'd0, 0);
    check("mid_rst_err", {31'd0, out_err}, 32'd0, 0);
    @(negedge clk);
    rst_n = 1'b1;
    spurious = 1'b0;
    repeat (ITER + 4) begin
      @(posedge clk);
      #1;
      if (out_valid) spurious = 1'b1;
    end
    check("mid_rst_no_result", {31'd0, spurious}, 32'd0, 0);
    legal("restart", TH_PI6, C6, S6);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
